// File: rtl/mux2_arb_pkg.sv
// Shared types and defaults for the two-source round-robin mux arbiter.
// Optional feature macro: ARB_LOCK_EN (burst lock FSM, see mux2_rr_arbiter).
package mux2_arb_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux2_arb_pick.sv
// Combinational grant picker for two requesters. A source is eligible when it
// is valid and its bit in mask_i is set (bit 0 = A, bit 1 = B). When both are
// eligible the priority bit decides; otherwise the lone eligible source wins.
module mux2_arb_pick
  import mux2_arb_pkg::*;
(
  input  logic       a_valid_i,
  input  logic       b_valid_i,
  input  logic       prio_i,
  input  logic [1:0] mask_i,
  output logic       grant_valid_o,
  output logic       grant_o
);

  logic a_elig;
  logic b_elig;

  // Eligibility, then priority resolution when both sources compete.
  always_comb begin
    a_elig        = a_valid_i && mask_i[0];
    b_elig        = b_valid_i && mask_i[1];
    grant_valid_o = a_elig || b_elig;
    if (a_elig && b_elig) begin
      grant_o = prio_i;
    end else if (b_elig) begin
      grant_o = SRC_B;
    end else begin
      grant_o = SRC_A;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between sources A and B, with a
// one-entry registered output stage and valid/ready handshakes on all sides.
// Optional macro ARB_LOCK_EN adds a_lock/b_lock ports and a two-state lock FSM
// that lets one source hold the mux for up to MAX_BURST consecutive transfers.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic             a_lock,
  input  logic             b_lock
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  src_t             out_sel_q,   out_sel_d;
  src_t             prio_q,      prio_d;

  logic       load;
  logic       xfer;
  logic [1:0] mask;
  logic       grant_valid;
  logic       grant_bit;
  src_t       grant;

  // The register can accept a word when empty or draining this same edge.
  assign load  = !out_valid_q || out_ready;
  assign grant = src_t'(grant_bit);
  assign xfer  = !reset && load && grant_valid;

  assign a_ready = xfer && (grant == SRC_A);
  assign b_ready = xfer && (grant == SRC_B);

  mux2_arb_pick u_pick (
    .a_valid_i    (a_valid),
    .b_valid_i    (b_valid),
    .prio_i       (prio_q),
    .mask_i       (mask),
    .grant_valid_o(grant_valid),
    .grant_o      (grant_bit)
  );

`ifdef ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  src_t          owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [BW-1:0] burst_inc;
  logic          grant_lock;
  logic          owner_valid;

  assign mask        = (state_q == ARB_LOCKED) ? ((owner_q == SRC_B) ? 2'b10 : 2'b01) : 2'b11;
  assign grant_lock  = (grant == SRC_B) ? b_lock : a_lock;
  assign owner_valid = (owner_q == SRC_B) ? b_valid : a_valid;

  // Lock FSM next state: enter on a locked transfer, leave on unlock, idle owner or full burst.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    prio_d    = prio_q;
    burst_inc = burst_q + 1'b1;
    case (state_q)
      ARB_RR: begin
        if (xfer) begin
          prio_d = src_t'(~grant);
          if (grant_lock && (MAX_BURST > 1)) begin
            state_d = ARB_LOCKED;
            owner_d = grant;
            burst_d = BW'(1);
          end
        end
      end
      ARB_LOCKED: begin
        if (load && !owner_valid) begin
          state_d = ARB_RR;
          burst_d = '0;
          prio_d  = src_t'(~owner_q);
        end else if (xfer) begin
          burst_d = burst_inc;
          if (!grant_lock || (burst_inc >= BW'(MAX_BURST))) begin
            state_d = ARB_RR;
            burst_d = '0;
            prio_d  = src_t'(~owner_q);
          end
        end
      end
      default: state_d = ARB_RR;
    endcase
  end

  // Lock FSM state, owner and burst counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_RR;
      owner_q <= SRC_A;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end
`else
  assign mask = 2'b11;

  // Plain round-robin: after each transfer the other source is favoured.
  always_comb begin
    prio_d = prio_q;
    if (xfer) begin
      prio_d = src_t'(~grant);
    end
  end
`endif

  // Output stage next state: refill on grant, empty on idle load, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = (grant == SRC_B) ? b_data : a_data;
        out_sel_d   = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register and priority bit; reset drops any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= SRC_A;
      prio_q      <= SRC_A;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      prio_q      <= prio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: the driver predicts grants from the
// arbitration rules and queues expected words; a monitor pops and compares
// each word as the consumer takes it. Builds with or without ARB_LOCK_EN.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] a_data = '0, b_data = '0;
  logic             a_lock = 1'b0, b_lock = 1'b0;
  logic             a_ready, b_ready, out_valid, out_sel;
  logic [WIDTH-1:0] out_data;

  int    checks = 0;
  int    errors = 0;
  word_t sb_q[$];

  // Reference model state
  bit m_prio = 1'b0;
  bit m_locked = 1'b0;
  bit m_owner = 1'b0;
  int m_count = 0;
  bit exp_a = 1'b0, exp_b = 1'b0;
  bit prev_reset = 1'b0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
`ifdef ARB_LOCK_EN
    ,
    .a_lock   (a_lock),
    .b_lock   (b_lock)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check readys at +1, update model at +3.
  task automatic step(input bit rst, input bit av, input logic [WIDTH-1:0] ad,
                      input bit bv, input logic [WIDTH-1:0] bd, input bit ordy,
                      input bit al, input bit bl);
    bit    held, ld, elig_a, elig_b, gv, g, lk;
    word_t w;
    @(negedge clk);
    reset = rst; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    out_ready = ordy; a_lock = al; b_lock = bl;
    #1;
    if (prev_reset) begin
      check("reset_out_valid", 32'(out_valid), 32'(0));
      check("reset_out_data", 32'(out_data), 32'(0));
      check("reset_out_sel", 32'(out_sel), 32'(0));
    end
    held   = (sb_q.size() != 0);
    ld     = !held || ordy;
    elig_a = av && (!m_locked || !m_owner);
    elig_b = bv && (!m_locked || m_owner);
    gv     = elig_a || elig_b;
    g      = (elig_a && elig_b) ? m_prio : elig_b;
    exp_a  = !rst && ld && gv && !g;
    exp_b  = !rst && ld && gv && g;
    check("a_ready", 32'(a_ready), 32'(exp_a));
    check("b_ready", 32'(b_ready), 32'(exp_b));
    #2;
    if (rst) begin
      sb_q.delete();
      m_prio = 1'b0; m_locked = 1'b0; m_count = 0;
    end else if (exp_a || exp_b) begin
      w.sel  = g;
      w.data = g ? bd : ad;
      sb_q.push_back(w);
      lk = g ? bl : al;
      if (!m_locked) begin
        m_prio = !g;
        if (LOCK_EN && lk && MAX_BURST > 1) begin
          m_locked = 1'b1; m_owner = g; m_count = 1;
        end
      end else begin
        m_count++;
        if (!lk || m_count >= MAX_BURST) begin
          m_locked = 1'b0; m_prio = !m_owner;
        end
      end
    end else if (m_locked && ld && !(m_owner ? bv : av)) begin
      m_locked = 1'b0; m_prio = !m_owner;
    end
    prev_reset = rst;
  endtask

  // Monitor: occupancy check every cycle, word comparison whenever the consumer takes one.
  always @(negedge clk) begin
    word_t w;
    #2;
    if (reset !== 1'b1) begin
      check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      if (out_valid === 1'b1 && out_ready === 1'b1 && sb_q.size() != 0) begin
        w = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(w.data));
        check("out_sel", 32'(out_sel), 32'(w.sel));
      end
    end
  end

  initial begin
    bit av, bv, rst;
    logic [WIDTH-1:0] ad, bd;
    // Reset, then a lone A request.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h3C, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    // Fresh reset, then alternating grants with both valid.
    step(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h11, 1, 8'h22, 1, 0, 0);
    // Backpressure for 3 cycles, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 8'h11, 1, 8'h22, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 8'h11, 1, 8'h22, 1, 0, 0);
    // Reset mid-stream while a word is held.
    step(1, 1, 8'h11, 1, 8'h22, 0, 0, 0);
    step(0, 1, 8'h11, 1, 8'h22, 1, 0, 0);
    step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
`ifdef ARB_LOCK_EN
    // Full burst on A, then B.
    step(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'hA0 + 8'(i), 1, 8'hB0 + 8'(i), 1, 1, 0);
    // Lock dropped on the second A transfer.
    step(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    step(0, 1, 8'h51, 1, 8'h61, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h52 + 8'(i), 1, 8'h62 + 8'(i), 1, 0, 0);
`endif
    // Randomized traffic; a valid source holds its word until accepted.
    av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!(av && !exp_a)) begin
        av = ($urandom_range(0, 2) != 0);
        ad = WIDTH'($urandom);
      end
      if (!(bv && !exp_b)) begin
        bv = ($urandom_range(0, 2) != 0);
        bd = WIDTH'($urandom);
      end
      step(rst, av, ad, bv, bd, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    // Drain.
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Sequential controller that shares one 2:1 datapath mux between two requesters, A and B, using valid/ready handshakes. It decides each cycle which source drives the mux. It drives the select line, with 0 selecting A and 1 selecting B. Data passes through a one-entry registered output stage. Selection is round-robin, so neither source can starve. The block sits between the two operand producers and the shared downstream consumer in the CPU datapath.

## Interface
- WIDTH, 8: data width of each source and of the output.
- MAX_BURST, 4: maximum consecutive grants to one source while locked. Used only with ARB_LOCK_EN.
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  source A offers data.
- a_data  input  WIDTH  source A payload.
- a_ready  output  1  source A transfer accepted this cycle.
- b_valid  input  1  source B offers data.
- b_data  input  WIDTH  source B payload.
- b_ready  output  1  source B transfer accepted this cycle.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered mux output.
- out_sel  output  1  source of the held data (0 = A, 1 = B).
- out_ready  input  1  consumer accepts out_data.
- a_lock, b_lock  input  1  burst-hold requests. Present only with ARB_LOCK_EN.

## Operation
- One clock. Reset is synchronous and active-high.
- The output register may load when `load = !out_valid || out_ready`.
- Grant rules:
  - Only one source valid: that source is granted.
  - Both valid: grant goes to the source named by the priority bit `prio` (0 = A).
  - Neither valid: no grant.
- Handshake outputs:
  - `a_ready = load && grant == A`.
  - `b_ready = load && grant == B`.
  - At most one ready is high in any cycle.
  - Ready is combinational from the valids and output state.
  - Ready never depends on ready.
- On transfer:
  - out_data takes the granted source's data.
  - out_sel takes the grant.
  - out_valid is set to 1.
  - prio flips to the non-granted source.
- With `load && !grant`: out_valid clears to 0. out_data and out_sel hold their values.
- Without `load`: all output registers hold. A valid source must hold its data stable until its ready is high.
- Width rule: data passes unmodified, with no extension or truncation.

## Timing
- Reset, checked at the clock edge while reset is high:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - prio = 0, so A is favoured first.
  - State = ARB_RR, burst count = 0.
  - a_ready and b_ready are forced to 0 throughout reset.
- Reset in mid-operation drops any held output word. No transfer completes in a reset cycle.
- Latency: a source handshake in cycle n gives out_valid = 1 with that data in cycle n+1.
- Throughput: one word per cycle while out_ready is held at 1.
- Backpressure: while `out_valid && !out_ready`, both readys are 0 and the output is stable.
- When out_ready = 1 in the same cycle as a new grant, the register drains and refills in that same edge, with no bubble.

## Configuration
- Macro: ARB_LOCK_EN. When it is defined, ports a_lock and b_lock exist and the block has a two-state FSM.
- ARB_RR: normal round-robin arbitration.
  - A transfer from X with X_lock = 1 moves the FSM to ARB_LOCKED with owner = X and burst count = 1.
- ARB_LOCKED: only the owner can be granted.
  - Each owner transfer increments the burst count. prio does not flip.
  - The FSM returns to ARB_RR and prio flips to the other source when any of these holds:
    - A transfer happens with X_lock = 0.
    - Owner valid is 0 during a load cycle.
    - The burst count reaches MAX_BURST on a transfer.
  - The other source waits, even when it is valid.
- When the macro is undefined, the lock ports and the FSM are absent and the block is always pure round-robin.

## Structure
- Package mux2_arb_pkg:
  - src_t enumeration with SRC_A = 1'b0 and SRC_B = 1'b1.
  - arb_state_t enumeration with ARB_RR and ARB_LOCKED.
  - Default WIDTH and MAX_BURST constants.
- Sub-module mux2_arb_pick:
  - Combinational picker.
  - Inputs: a_valid, b_valid, prio, and an optional owner mask.
  - Outputs: grant_valid and grant src_t.
- The top level holds the output register, the prio flip-flop and the lock FSM/counter.

## Test plan
- Reset, then a_valid = 1 with a_data = 8'h3C and b_valid = 0 → a_ready = 1. In the next cycle out_valid = 1, out_data = 8'h3C, out_sel = 0.
- Both valid for 4 cycles with out_ready = 1, A = 8'h11 and B = 8'h22 → out_data sequence 11, 22, 11, 22 and out_sel sequence 0, 1, 0, 1.
- Hold out_valid = 1 and out_ready = 0 for 3 cycles with both sources valid → a_ready = b_ready = 0. out_data is unchanged. The first transfer after release goes to the source named by prio.
- Assert reset for 1 cycle mid-stream with out_valid = 1 → out_valid = 0, out_data = 0, and the next grant with both valid goes to A.
- ARB_LOCK_EN build with MAX_BURST = 4, a_lock held at 1 and both valid → four consecutive A grants, then one B grant. b_ready stays 0 during the burst.
- ARB_LOCK_EN build, with a_lock dropped after 2 A transfers → the next grant goes to B and the FSM returns to ARB_RR.
